// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types (ALU opcodes, data word, arbiter buffer state)
package cpu_types_pkg;
  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SLL  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_SLTU = 4'h9
  } aluop_t;
  typedef enum logic {ARB_EMPTY, ARB_FULL} arb_state_t;
endpackage

// File: rtl/alu_if.sv
// alu_if: connection bundle between an ALU user (master) and the combinational ALU (slave)
//   op/a/b           : operation and operands, driven by the master
//   out/zero/neg/ovf : result and flags, driven by the ALU
interface alu_if;
  import cpu_types_pkg::*;
  aluop_t op;
  word_t  a;
  word_t  b;
  word_t  out;
  logic   zero;
  logic   neg;
  logic   overflow;
  modport master (output op, a, b, input out, zero, neg, overflow);
  modport slave  (input op, a, b, output out, zero, neg, overflow);
endinterface

// File: rtl/alu.sv
// alu: 32-bit combinational ALU
//   bus (alu_if.slave): op/a/b in; out, zero, neg, overflow out
//   shifts use b[4:0]; ADD/SUB overflow is signed; undefined ops give out=0
module alu
  import cpu_types_pkg::*;
(
  alu_if.slave bus
);
  word_t w_sum;
  word_t w_diff;
  assign w_sum  = bus.a + bus.b;
  assign w_diff = bus.a - bus.b;
  always_comb begin
    bus.out      = '0;
    bus.overflow = 1'b0;
    case (bus.op)
      ALU_ADD: begin
        bus.out      = w_sum;
        bus.overflow = (bus.a[31] == bus.b[31]) && (w_sum[31] != bus.a[31]);
      end
      ALU_SUB: begin
        bus.out      = w_diff;
        bus.overflow = (bus.a[31] != bus.b[31]) && (w_diff[31] != bus.a[31]);
      end
      ALU_AND:  bus.out = bus.a & bus.b;
      ALU_OR:   bus.out = bus.a | bus.b;
      ALU_XOR:  bus.out = bus.a ^ bus.b;
      ALU_SLL:  bus.out = bus.a << bus.b[4:0];
      ALU_SRL:  bus.out = bus.a >> bus.b[4:0];
      ALU_SRA:  bus.out = word_t'($signed(bus.a) >>> bus.b[4:0]);
      ALU_SLT:  bus.out = {31'b0, $signed(bus.a) < $signed(bus.b)};
      ALU_SLTU: bus.out = {31'b0, bus.a < bus.b};
      default:  bus.out = '0;
    endcase
  end
  assign bus.zero = (bus.out == '0);
  assign bus.neg  = bus.out[31];
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between NREQ requesters with a one-entry response buffer
//   CLK, nRST            : clock (rising edge), async active-low reset
//   req_valid/req_ready  : per-requester request handshake; req_ready one-hot or zero
//   req_op/req_a/req_b   : per-requester ALU operation and operands
//   rsp_valid/rsp_ready  : response handshake, rsp_valid one-hot to the owner rsp_id
//   rsp_out/zero/neg/overflow, rsp_id : buffered result, flags and owner
//   busy                 : response buffer full
module alu_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  aluop_t          req_op [NREQ],
  input  word_t           req_a  [NREQ],
  input  word_t           req_b  [NREQ],
  output logic [NREQ-1:0] rsp_valid,
  input  logic [NREQ-1:0] rsp_ready,
  output word_t           rsp_out,
  output logic            rsp_zero,
  output logic            rsp_neg,
  output logic            rsp_overflow,
  output logic [IDW-1:0]  rsp_id,
  output logic            busy
);
  arb_state_t     r_state;
  arb_state_t     w_state_nxt;
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] r_id;
  word_t          r_out;
  logic           r_zero;
  logic           r_neg;
  logic           r_ovf;
  logic [IDW-1:0] w_idx;
  logic [IDW-1:0] w_sel;
  logic           w_found;
  logic           w_drain;
  logic           w_can_accept;
  logic           w_fire;
  logic [NREQ-1:0] w_rsp_valid;
  alu_if u_alu_if ();
  alu u_alu (.bus(u_alu_if));

  // Returns {found, index} of the valid requester closest to ptr going upward with wrap.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid, input logic [IDW-1:0] ptr);
    logic [IDW:0] pick;
    int best;
    int d;
    pick = '0;
    best = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      d = (i + NREQ - int'(ptr)) % NREQ;
      if (valid[i] && d < best) begin
        best = d;
        pick = {1'b1, IDW'(i)};
      end
    end
    return pick;
  endfunction

  assign {w_found, w_idx} = rr_pick(req_valid, r_rr_ptr);
  assign w_drain      = |(w_rsp_valid & rsp_ready);
  assign w_can_accept = (r_state == ARB_EMPTY) || w_drain;
  assign w_fire       = w_found && w_can_accept && nRST;
  // Idle cycles still feed the ALU from the pointer requester; the result is simply not captured.
  assign w_sel        = w_found ? w_idx : r_rr_ptr;

  always_comb begin
    w_rsp_valid = '0;
    req_ready   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_rsp_valid[i] = (r_state == ARB_FULL) && (r_id == IDW'(i));
      req_ready[i]   = w_fire && (w_idx == IDW'(i));
    end
    w_state_nxt = r_state;
    w_state_nxt = w_fire ? ARB_FULL : (w_drain ? ARB_EMPTY : r_state);
  end

  always_comb begin
    u_alu_if.op = req_op[0];
    u_alu_if.a  = req_a[0];
    u_alu_if.b  = req_b[0];
    for (int i = 1; i < NREQ; i++) begin
      if (w_sel == IDW'(i)) begin
        u_alu_if.op = req_op[i];
        u_alu_if.a  = req_a[i];
        u_alu_if.b  = req_b[i];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= ARB_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // Data registers only load on a handshake, so a plain drain leaves the last result visible.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_rr_ptr <= '0;
      r_id     <= '0;
      r_out    <= '0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_fire) begin
      r_rr_ptr <= IDW'((int'(w_idx) + 1) % NREQ);
      r_id     <= w_idx;
      r_out    <= u_alu_if.out;
      r_zero   <= u_alu_if.zero;
      r_neg    <= u_alu_if.neg;
      r_ovf    <= u_alu_if.overflow;
    end
  end

  assign rsp_valid    = w_rsp_valid;
  assign rsp_out      = r_out;
  assign rsp_zero     = r_zero;
  assign rsp_neg      = r_neg;
  assign rsp_overflow = r_ovf;
  assign rsp_id       = r_id;
  assign busy         = (r_state == ARB_FULL);
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter (NREQ=2)
module tb_alu_arbiter;
  import cpu_types_pkg::*;
  localparam int NREQ = 2;
  localparam int IDW  = 2;
  logic            CLK = 1'b0;
  logic            nRST;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  aluop_t          req_op [NREQ];
  word_t           req_a  [NREQ];
  word_t           req_b  [NREQ];
  logic [NREQ-1:0] rsp_valid;
  logic [NREQ-1:0] rsp_ready;
  word_t           rsp_out;
  logic            rsp_zero;
  logic            rsp_neg;
  logic            rsp_overflow;
  logic [IDW-1:0]  rsp_id;
  logic            busy;
  int n_checks = 0;
  int n_fail   = 0;
  int g [4] = '{1, 0, 1, 0};

  alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out(rsp_out), .rsp_zero(rsp_zero), .rsp_neg(rsp_neg),
    .rsp_overflow(rsp_overflow), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input aluop_t op, input word_t a, input word_t b);
    req_op[i] = op;
    req_a[i]  = a;
    req_b[i]  = b;
  endtask

  initial begin
    nRST      = 1'b0;
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    set_req(0, ALU_ADD, 32'd0, 32'd0);
    set_req(1, ALU_ADD, 32'd0, 32'd0);
    @(negedge CLK);
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_valid", rsp_valid, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out", rsp_out, 32'h0);
    chk("rst_id", rsp_id, 2'd0);
    req_valid = 2'b00;
    tick();
    nRST = 1'b1;
    // single request: signed overflow on ADD
    set_req(0, ALU_ADD, 32'h7FFFFFFF, 32'h1);
    req_valid = 2'b01;
    rsp_ready = 2'b11;
    @(negedge CLK);
    chk("single_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    @(negedge CLK);
    chk("single_valid", rsp_valid, 2'b01);
    chk("single_out", rsp_out, 32'h80000000);
    chk("single_ovf", rsp_overflow, 1'b1);
    chk("single_neg", rsp_neg, 1'b1);
    chk("single_zero", rsp_zero, 1'b0);
    chk("single_id", rsp_id, 2'd0);
    tick();
    // contention: pointer is 1 after the grant to requester 0
    set_req(0, ALU_SUB, 32'd5, 32'd5);
    set_req(1, ALU_SLTU, 32'd1, 32'd2);
    req_valid = 2'b11;
    @(negedge CLK);
    chk("ct_idle_valid", rsp_valid, 2'b00);
    for (int k = 0; k < 4; k++) begin
      if (k != 0) @(negedge CLK);
      chk("ct_ready", req_ready, 32'(1) << g[k]);
      if (k > 0) begin
        chk("ct_rsp_valid", rsp_valid, 32'(1) << g[k-1]);
        chk("ct_rsp_out", rsp_out, (g[k-1] == 1) ? 32'd1 : 32'd0);
        chk("ct_rsp_zero", rsp_zero, (g[k-1] == 0) ? 32'd1 : 32'd0);
      end
      tick();
    end
    req_valid = 2'b00;
    @(negedge CLK);
    chk("ct_last_valid", rsp_valid, 2'b01);
    chk("ct_last_zero", rsp_zero, 1'b1);
    tick();
    // backpressure: owner 1 stalls, non-owner ready bit must be ignored
    set_req(0, ALU_ADD, 32'd3, 32'd4);
    set_req(1, ALU_SRA, 32'h80000000, 32'd4);
    req_valid = 2'b11;
    rsp_ready = 2'b01;
    @(negedge CLK);
    chk("bp_grant1", req_ready, 2'b10);
    tick();
    req_valid = 2'b01;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("bp_stall_ready", req_ready, 2'b00);
      chk("bp_stall_valid", rsp_valid, 2'b10);
      chk("bp_stall_out", rsp_out, 32'hF8000000);
      chk("bp_stall_id", rsp_id, 2'd1);
      chk("bp_stall_busy", busy, 1'b1);
      tick();
    end
    rsp_ready = 2'b11;
    @(negedge CLK);
    chk("bp_drain_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    @(negedge CLK);
    chk("bp_next_valid", rsp_valid, 2'b01);
    chk("bp_next_out", rsp_out, 32'd7);
    chk("bp_next_busy", busy, 1'b1);
    tick();
    // undefined opcode
    set_req(0, aluop_t'(4'hF), 32'hFFFFFFFF, 32'hFFFFFFFF);
    req_valid = 2'b01;
    @(negedge CLK);
    chk("undef_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    @(negedge CLK);
    chk("undef_valid", rsp_valid, 2'b01);
    chk("undef_out", rsp_out, 32'h0);
    chk("undef_zero", rsp_zero, 1'b1);
    chk("undef_ovf", rsp_overflow, 1'b0);
    // async reset while the buffer is full
    @(posedge CLK);
    #2;
    nRST = 1'b0;
    #1;
    chk("mrst_valid", rsp_valid, 2'b00);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_out", rsp_out, 32'h0);
    chk("mrst_zero", rsp_zero, 1'b0);
    tick();
    nRST = 1'b1;
    set_req(0, ALU_SUB, 32'd5, 32'd5);
    set_req(1, ALU_SLTU, 32'd1, 32'd2);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    @(negedge CLK);
    chk("mrst_first_grant", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    @(negedge CLK);
    chk("mrst_rsp_valid", rsp_valid, 2'b01);
    chk("mrst_rsp_id", rsp_id, 2'd0);
    chk("mrst_rsp_zero", rsp_zero, 1'b1);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
